// File: rtl/parity_pkg.sv
// Shared types and helpers for the serial parity transmitter.
package parity_pkg;

  // Frame sequencing: idle, N data bits, one parity bit.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2
  } state_t;

  // Widest word calc_parity can reduce; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int unsigned MAX_WIDTH = 256;

  // Bit counter width: max(1, $clog2(n)) so N = 1 still gets a real flop.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Parity bit such that the ones count over {parity, data} is odd when
  // odd_mode is set and even otherwise.
  function automatic logic calc_parity(input logic [MAX_WIDTH-1:0] data,
                                       input logic                 odd_mode);
    return (^data) ^ odd_mode;
  endfunction

endpackage

// File: rtl/serial_parity_tx_if.sv
// Word-in / serial-out bundle for serial_parity_tx.
// slave is the transmitter side, master is the producer/consumer side.
interface serial_parity_tx_if #(
  parameter int unsigned N = 4
);
  logic [N-1:0] data_in;
  logic         data_valid;
  logic         data_ready;
  logic         odd_mode;
  logic [N:0]   parity_data;
  logic         parity;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic         busy;

  modport slave (
    input  data_in, data_valid, odd_mode,
    output data_ready, parity_data, parity, ser_out, ser_valid, ser_last, busy
  );

  modport master (
    output data_in, data_valid, odd_mode,
    input  data_ready, parity_data, parity, ser_out, ser_valid, ser_last, busy
  );
endinterface

// File: rtl/serial_parity_tx_parity_calc.sv
// Combinational parity generator with odd/even select.
module parity_calc
  import parity_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0] data,
  input  logic         odd_mode,
  output logic         parity
);

  // Reduce the word through the shared helper so all users agree on the rule.
  assign parity = calc_parity(MAX_WIDTH'(data), odd_mode);

endmodule

// File: rtl/serial_parity_tx.sv
// Parity generator and LSB-first serialiser: accepts an N-bit word, exposes
// {parity, data} in parallel and streams N data bits then the parity bit.
module serial_parity_tx
  import parity_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_parity_tx_if.slave    bus
);

  localparam int unsigned CNT_W = cnt_width(N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  state_t           state_q, state_d;
  logic [N-1:0]     shift_q, shift_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             par_q, par_d;
  logic [N:0]       parity_data_q, parity_data_d;

  logic             in_parity;
  logic             accept;

  parity_calc #(.N(N)) u_parity_calc (
    .data     (bus.data_in),
    .odd_mode (bus.odd_mode),
    .parity   (in_parity)
  );

  // Ready in IDLE and in the final (parity) cycle so frames can run back to back;
  // forced low during reset so reset always wins over an accept.
  assign bus.data_ready = !rst && ((state_q == IDLE) || (state_q == PARITY));
  assign accept         = bus.data_valid && bus.data_ready;

  // Next-state logic: frame sequencing, shifting and capture of a new word.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d       = state_q;
    shift_d       = shift_q;
    cnt_d         = cnt_q;
    par_d         = par_q;
    parity_data_d = parity_data_q;

    case (state_q)
      IDLE:    state_d = IDLE;
      DATA: begin
        shift_d = shift_q >> 1;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = PARITY;
      end
      PARITY:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A new word overrides the frame bookkeeping; parity is latched separately
    // so the bit being emitted is unaffected by a concurrent parity_data update.
    if (accept) begin
      shift_d       = bus.data_in;
      cnt_d         = '0;
      par_d         = in_parity;
      parity_data_d = {in_parity, bus.data_in};
      state_d       = DATA;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state_q       <= IDLE;
      shift_q       <= '0;
      cnt_q         <= '0;
      par_q         <= 1'b0;
      parity_data_q <= '0;
    end else begin
      state_q       <= state_d;
      shift_q       <= shift_d;
      cnt_q         <= cnt_d;
      par_q         <= par_d;
      parity_data_q <= parity_data_d;
    end
  end

  // Serial outputs decoded from the current state.
  always_comb begin
    bus.ser_out   = 1'b0;
    bus.ser_valid = 1'b0;
    bus.ser_last  = 1'b0;
    case (state_q)
      DATA: begin
        bus.ser_out   = shift_q[0];
        bus.ser_valid = 1'b1;
      end
      PARITY: begin
        bus.ser_out   = par_q;
        bus.ser_valid = 1'b1;
        bus.ser_last  = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.busy        = (state_q != IDLE);
  assign bus.parity_data = parity_data_q;
  assign bus.parity      = parity_data_q[N];

endmodule

// File: tb/tb_serial_parity_tx.sv
// Directed bench for serial_parity_tx at N = 4, plus N = 1 and N = 8 sweeps.
module tb_serial_parity_tx;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  serial_parity_tx_if #(.N(4)) bus4 ();
  serial_parity_tx_if #(.N(1)) bus1 ();
  serial_parity_tx_if #(.N(8)) bus8 ();

  serial_parity_tx #(.N(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));
  serial_parity_tx #(.N(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  serial_parity_tx #(.N(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  // Reset held 3 cycles with a word offered; then outputs after release.
  task automatic test_reset();
    rst = 1'b1;
    bus4.data_in = 4'hF; bus4.odd_mode = 1'b1; bus4.data_valid = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (bus4.data_ready !== 1'b0) $display("FAIL reset_ready_in_rst: got %b want 0", bus4.data_ready); else n_pass++;
    n_checks++;
    if (bus4.busy !== 1'b0) $display("FAIL reset_priority_busy: got %b want 0", bus4.busy); else n_pass++;
    bus4.data_valid = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (bus4.ser_valid !== 1'b0) $display("FAIL reset_ser_valid: got %b want 0", bus4.ser_valid); else n_pass++;
    n_checks++;
    if (bus4.busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus4.busy); else n_pass++;
    n_checks++;
    if (bus4.parity_data !== 5'b00000) $display("FAIL reset_parity_data: got %b want 00000", bus4.parity_data); else n_pass++;
    n_checks++;
    if (bus4.data_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus4.data_ready); else n_pass++;
    n_checks++;
    if ({bus4.ser_out, bus4.ser_last, bus4.parity} !== 3'b000)
      $display("FAIL reset_ser_out_last_parity: got %b want 000", {bus4.ser_out, bus4.ser_last, bus4.parity});
    else n_pass++;
  endtask

  // 4'b1011 with odd parity: parity 0, stream 1,1,0,1,0.
  task automatic test_single_frame();
    logic [4:0] exp_bits;
    exp_bits = 5'b01011;
    @(negedge clk);
    bus4.data_in = 4'b1011; bus4.odd_mode = 1'b1; bus4.data_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        // Changing inputs mid-frame must not affect this frame.
        bus4.data_valid = 1'b0; bus4.data_in = 4'b0000; bus4.odd_mode = 1'b0;
        n_checks++;
        if (bus4.parity_data !== 5'b01011) $display("FAIL single_parity_data: got %b want 01011", bus4.parity_data); else n_pass++;
      end
      n_checks++;
      if (bus4.ser_out !== exp_bits[k]) $display("FAIL single_ser_out[%0d]: got %b want %b", k, bus4.ser_out, exp_bits[k]); else n_pass++;
      n_checks++;
      if (bus4.ser_valid !== 1'b1) $display("FAIL single_ser_valid[%0d]: got %b want 1", k, bus4.ser_valid); else n_pass++;
      n_checks++;
      if (bus4.ser_last !== (k == 4)) $display("FAIL single_ser_last[%0d]: got %b want %b", k, bus4.ser_last, (k == 4)); else n_pass++;
      n_checks++;
      if (bus4.data_ready !== (k == 4)) $display("FAIL single_ready[%0d]: got %b want %b", k, bus4.data_ready, (k == 4)); else n_pass++;
    end
    @(negedge clk);
    n_checks++;
    if ({bus4.ser_valid, bus4.busy, bus4.ser_out} !== 3'b000)
      $display("FAIL single_idle_after: got %b want 000", {bus4.ser_valid, bus4.busy, bus4.ser_out});
    else n_pass++;
  endtask

  // 4'b0000 odd then even: frames 0,0,0,0,1 and 0,0,0,0,0.
  task automatic test_zero_parity();
    logic [4:0] exp_bits;
    @(negedge clk);
    for (int m = 1; m >= 0; m--) begin
      exp_bits = (m == 1) ? 5'b10000 : 5'b00000;
      bus4.data_in = 4'b0000; bus4.odd_mode = m[0]; bus4.data_valid = 1'b1;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        if (k == 0) begin
          bus4.data_valid = 1'b0;
          n_checks++;
          if (bus4.parity !== exp_bits[4]) $display("FAIL zero_parity_mode%0d: got %b want %b", m, bus4.parity, exp_bits[4]); else n_pass++;
        end
        n_checks++;
        if (bus4.ser_out !== exp_bits[k]) $display("FAIL zero_ser_out_mode%0d[%0d]: got %b want %b", m, k, bus4.ser_out, exp_bits[k]); else n_pass++;
      end
    end
    @(negedge clk);
  endtask

  // data_valid held: 4'hA then 4'h5 even mode, no gap between frames.
  task automatic test_back_to_back();
    logic [9:0] exp_bits;
    exp_bits = {5'b00101, 5'b01010};
    @(negedge clk);
    bus4.data_in = 4'hA; bus4.odd_mode = 1'b0; bus4.data_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k == 0) bus4.data_in = 4'h5;
      if (k == 5) bus4.data_valid = 1'b0;
      n_checks++;
      if (bus4.ser_valid !== 1'b1) $display("FAIL b2b_ser_valid[%0d]: got %b want 1", k, bus4.ser_valid); else n_pass++;
      n_checks++;
      if (bus4.ser_out !== exp_bits[k]) $display("FAIL b2b_ser_out[%0d]: got %b want %b", k, bus4.ser_out, exp_bits[k]); else n_pass++;
      n_checks++;
      if (bus4.ser_last !== (k == 4 || k == 9)) $display("FAIL b2b_ser_last[%0d]: got %b want %b", k, bus4.ser_last, (k == 4 || k == 9)); else n_pass++;
      if (k == 4) begin
        n_checks++;
        if (bus4.data_ready !== 1'b1) $display("FAIL b2b_ready_in_parity: got %b want 1", bus4.data_ready); else n_pass++;
        n_checks++;
        if (bus4.parity_data !== 5'b01010) $display("FAIL b2b_parity_data_first: got %b want 01010", bus4.parity_data); else n_pass++;
      end
      if (k == 5) begin
        n_checks++;
        if (bus4.parity_data !== 5'b00101) $display("FAIL b2b_parity_data_second: got %b want 00101", bus4.parity_data); else n_pass++;
      end
    end
    @(negedge clk);
    n_checks++;
    if ({bus4.ser_valid, bus4.busy} !== 2'b00) $display("FAIL b2b_idle_after: got %b want 00", {bus4.ser_valid, bus4.busy}); else n_pass++;
  endtask

  // Reset after two data bits of 4'hF aborts the frame.
  task automatic test_reset_mid_frame();
    logic seen_last;
    logic seen_valid;
    @(negedge clk);
    bus4.data_in = 4'hF; bus4.odd_mode = 1'b1; bus4.data_valid = 1'b1;
    @(negedge clk);
    bus4.data_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (bus4.ser_out !== 1'b1 || bus4.ser_valid !== 1'b1)
      $display("FAIL midrst_second_bit: got out=%b valid=%b want 1 1", bus4.ser_out, bus4.ser_valid);
    else n_pass++;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if (bus4.ser_valid !== 1'b0) $display("FAIL midrst_ser_valid: got %b want 0", bus4.ser_valid); else n_pass++;
    n_checks++;
    if (bus4.busy !== 1'b0) $display("FAIL midrst_busy: got %b want 0", bus4.busy); else n_pass++;
    n_checks++;
    if (bus4.parity_data !== 5'b00000) $display("FAIL midrst_parity_data: got %b want 00000", bus4.parity_data); else n_pass++;
    n_checks++;
    if (bus4.data_ready !== 1'b0) $display("FAIL midrst_ready: got %b want 0", bus4.data_ready); else n_pass++;
    rst = 1'b0;
    seen_last  = bus4.ser_last;
    seen_valid = bus4.ser_valid;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      seen_last  = seen_last | bus4.ser_last;
      seen_valid = seen_valid | bus4.ser_valid;
    end
    n_checks++;
    if (seen_last !== 1'b0) $display("FAIL midrst_no_last: got %b want 0", seen_last); else n_pass++;
    n_checks++;
    if (seen_valid !== 1'b0) $display("FAIL midrst_no_valid: got %b want 0", seen_valid); else n_pass++;
  endtask

  // N = 4 sweep, both modes, frames back to back.
  task automatic test_sweep_n4();
    int  ones;
    logic shape_ok;
    logic exp_p;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      for (int d = 0; d < 16; d++) begin
        exp_p = logic'($countones(d) % 2) ^ m[0];
        bus4.data_in = 4'(d); bus4.odd_mode = m[0]; bus4.data_valid = 1'b1;
        ones = 0; shape_ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          if (k == 0) begin
            bus4.data_valid = 1'b0; bus4.data_in = ~bus4.data_in; bus4.odd_mode = ~bus4.odd_mode;
            n_checks++;
            if (bus4.parity_data !== {exp_p, 4'(d)})
              $display("FAIL sweep4_parity_data m=%0d d=%0d: got %b want %b", m, d, bus4.parity_data, {exp_p, 4'(d)});
            else n_pass++;
          end
          ones += int'(bus4.ser_out);
          if (bus4.ser_valid !== 1'b1 || bus4.ser_last !== (k == 4)) shape_ok = 1'b0;
        end
        n_checks++;
        if ((ones % 2) != m) $display("FAIL sweep4_ones m=%0d d=%0d: got %0d ones want parity %0d", m, d, ones, m); else n_pass++;
        n_checks++;
        if (shape_ok !== 1'b1) $display("FAIL sweep4_shape m=%0d d=%0d: got %b want 1", m, d, shape_ok); else n_pass++;
      end
    end
    @(negedge clk);
  endtask

  // N = 1 build: DATA lasts a single cycle.
  task automatic test_sweep_n1();
    int  ones;
    logic shape_ok;
    logic exp_p;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      for (int d = 0; d < 2; d++) begin
        exp_p = logic'(d % 2) ^ m[0];
        bus1.data_in = 1'(d); bus1.odd_mode = m[0]; bus1.data_valid = 1'b1;
        ones = 0; shape_ok = 1'b1;
        for (int k = 0; k < 2; k++) begin
          @(negedge clk);
          if (k == 0) begin
            bus1.data_valid = 1'b0; bus1.data_in = ~bus1.data_in; bus1.odd_mode = ~bus1.odd_mode;
            n_checks++;
            if (bus1.parity_data !== {exp_p, 1'(d)})
              $display("FAIL sweep1_parity_data m=%0d d=%0d: got %b want %b", m, d, bus1.parity_data, {exp_p, 1'(d)});
            else n_pass++;
          end
          ones += int'(bus1.ser_out);
          if (bus1.ser_valid !== 1'b1 || bus1.ser_last !== (k == 1)) shape_ok = 1'b0;
        end
        n_checks++;
        if ((ones % 2) != m) $display("FAIL sweep1_ones m=%0d d=%0d: got %0d ones want parity %0d", m, d, ones, m); else n_pass++;
        n_checks++;
        if (shape_ok !== 1'b1) $display("FAIL sweep1_shape m=%0d d=%0d: got %b want 1", m, d, shape_ok); else n_pass++;
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus1.busy !== 1'b0) $display("FAIL sweep1_idle_after: got %b want 0", bus1.busy); else n_pass++;
  endtask

  // N = 8 build: full byte sweep, both modes.
  task automatic test_sweep_n8();
    int  ones;
    logic shape_ok;
    logic exp_p;
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      for (int d = 0; d < 256; d++) begin
        exp_p = logic'($countones(d) % 2) ^ m[0];
        bus8.data_in = 8'(d); bus8.odd_mode = m[0]; bus8.data_valid = 1'b1;
        ones = 0; shape_ok = 1'b1;
        for (int k = 0; k < 9; k++) begin
          @(negedge clk);
          if (k == 0) begin
            bus8.data_valid = 1'b0; bus8.data_in = ~bus8.data_in; bus8.odd_mode = ~bus8.odd_mode;
            n_checks++;
            if (bus8.parity_data !== {exp_p, 8'(d)})
              $display("FAIL sweep8_parity_data m=%0d d=%0d: got %b want %b", m, d, bus8.parity_data, {exp_p, 8'(d)});
            else n_pass++;
          end
          ones += int'(bus8.ser_out);
          if (bus8.ser_valid !== 1'b1 || bus8.ser_last !== (k == 8)) shape_ok = 1'b0;
        end
        n_checks++;
        if ((ones % 2) != m) $display("FAIL sweep8_ones m=%0d d=%0d: got %0d ones want parity %0d", m, d, ones, m); else n_pass++;
        n_checks++;
        if (shape_ok !== 1'b1) $display("FAIL sweep8_shape m=%0d d=%0d: got %b want 1", m, d, shape_ok); else n_pass++;
      end
    end
    @(negedge clk);
    n_checks++;
    if (bus8.busy !== 1'b0) $display("FAIL sweep8_idle_after: got %b want 0", bus8.busy); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    bus4.data_in = '0; bus4.data_valid = 1'b0; bus4.odd_mode = 1'b0;
    bus1.data_in = '0; bus1.data_valid = 1'b0; bus1.odd_mode = 1'b0;
    bus8.data_in = '0; bus8.data_valid = 1'b0; bus8.odd_mode = 1'b0;
    test_reset();
    test_single_frame();
    test_zero_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_sweep_n4();
    test_sweep_n1();
    test_sweep_n8();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
